// File: rtl/out_tx_pkg.sv
// Shared types and constants for the output-port UART transmitter.
// The PARITY state is always declared; only builds with OUT_TX_PARITY_EN reach it.
package out_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/out_port_uart_tx_if.sv
// CPU-side write port and serial/status outputs of the output-port UART transmitter.
interface out_port_uart_tx_if
    import out_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
);
    logic [DATA_BITS-1:0]         out_data;
    logic                         out_wr;
    logic                         tx;
    logic                         busy;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         full;
    logic                         overflow;

    modport master (output out_data, out_wr,
                    input  tx, busy, fifo_count, full, overflow);
    modport slave  (input  out_data, out_wr,
                    output tx, busy, fifo_count, full, overflow);
endinterface

// File: rtl/out_tx_fifo.sv
// Synchronous FIFO with show-ahead head data; a push into a full queue is
// accepted when a pop happens on the same edge.
module out_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        data_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/out_port_uart_tx.sv
// Queues CPU output-port bytes and serialises them as 8N1 UART frames, LSB first.
// Define OUT_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module out_port_uart_tx
    import out_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              CLK,
    input  logic              reset,
    out_port_uart_tx_if.slave bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    tx_state_t               state_q;
    logic [BW-1:0]           baud_q;
    logic [2:0]              bit_idx_q;
    logic [DATA_BITS-1:0]    shift_q;
    logic                    tx_q;
    logic                    overflow_q;

    logic [DATA_BITS-1:0]         fifo_head;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         pop;
    logic                         baud_end;

    out_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (reset),
        .push_i  (bus.out_wr),
        .pop_i   (pop),
        .data_i  (bus.out_data),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));
    // Loading from STOP as well as IDLE is what makes queued frames back-to-back.
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && baud_end));

`ifdef OUT_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^fifo_head;
        end
    end
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (bus.out_wr && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            baud_q <= ((state_q == IDLE) || baud_end) ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= fifo_head;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef OUT_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        if (pop) begin
                            shift_q <= fifo_head;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != IDLE) || (fifo_count != '0);
    assign bus.fifo_count = fifo_count;
    assign bus.full       = fifo_full;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_out_port_uart_tx.sv
// Self-checking bench for out_port_uart_tx: table-driven single frames, a UART
// receiver checked against a queue of expected bytes, and multi-cycle corner cases.
module tb_out_port_uart_tx;
    localparam int N     = 4;
    localparam int DEPTH = 8;
`ifdef OUT_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * N;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;
        logic       parity;
    } vec_t;

    logic CLK = 1'b0;
    logic reset;

    out_port_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    out_port_uart_tx #(
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int         assertCount = 0;
    int         failCount   = 0;
    logic [7:0] expQ[$];
    int         startCycles[$];
    int         framesSeen  = 0;
    int         globalCycle = 0;
    vec_t       vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; holds the byte on the port for the next rising edge.
    task automatic applyStimulus(input logic [7:0] d, input bit accept);
        bus.out_data = d;
        bus.out_wr   = 1'b1;
        if (accept) expQ.push_back(d);
        @(negedge CLK);
    endtask

    task automatic waitIdle(input int maxCyc, output int peak);
        peak = 0;
        for (int c = 0; c < maxCyc && bus.busy; c++) begin
            if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
            @(negedge CLK);
        end
        checkOutput("drain_busy", bus.busy, 0);
    endtask

    function automatic logic expBit(input vec_t v, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return v.seq[8-k];
        if (FRAME_BITS == 11 && k == 9) return v.parity;
        return 1'b1;
    endfunction

    // UART receiver: samples mid-bit and checks each frame against the queue.
    initial begin
        bit         rxActive = 0;
        int         rxCyc    = 0;
        int         k;
        logic [7:0] rxByte   = '0;
        logic       rxPar    = 1'b0;
        logic [7:0] expByte;
        forever begin
            @(negedge CLK);
            globalCycle++;
            if (reset) begin
                rxActive = 0;
            end else begin
                if (!rxActive && bus.tx == 1'b0) begin
                    rxActive = 1;
                    rxCyc    = 0;
                    startCycles.push_back(globalCycle);
                end
                if (rxActive) begin
                    if (rxCyc % N == N / 2) begin
                        k = rxCyc / N;
                        if (k == 0) begin
                            checkOutput("rx_start", bus.tx, 0);
                        end else if (k <= 8) begin
                            rxByte[k-1] = bus.tx;
                        end else if (k < FRAME_BITS - 1) begin
                            rxPar = bus.tx;
                        end else begin
                            checkOutput("rx_stop", bus.tx, 1);
                            checkOutput("rx_frame_expected", expQ.size() > 0, 1);
                            if (expQ.size() > 0) begin
                                expByte = expQ.pop_front();
                                checkOutput("rx_data", rxByte, expByte);
                                if (FRAME_BITS == 11) checkOutput("rx_parity", rxPar, ^expByte);
                            end
                            framesSeen++;
                            rxActive = 0;
                        end
                    end
                    rxCyc++;
                end
            end
        end
    end

    initial begin
        int f0;
        int s0;
        int peak;

        vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
        vecs[1] = '{8'h07, 8'b11100000, 1'b1};
        vecs[2] = '{8'h03, 8'b11000000, 1'b0};
        vecs[3] = '{8'h80, 8'b00000001, 1'b1};
        vecs[4] = '{8'h00, 8'b00000000, 1'b0};
        vecs[5] = '{8'h6E, 8'b01110110, 1'b1};

        reset        = 1'b1;
        bus.out_wr   = 1'b0;
        bus.out_data = '0;
        #1;
        checkOutput("rst_tx", bus.tx, 1);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_count", bus.fifo_count, 0);
        checkOutput("rst_full", bus.full, 0);
        checkOutput("rst_overflow", bus.overflow, 0);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);

        $display("[TB] single frames from vector table");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data, 1);
            bus.out_wr = 1'b0;
            checkOutput($sformatf("vec%0d_pre_tx", i), bus.tx, 1);
            checkOutput($sformatf("vec%0d_pre_count", i), bus.fifo_count, 1);
            checkOutput($sformatf("vec%0d_pre_busy", i), bus.busy, 1);
            @(negedge CLK);
            for (int c = 0; c < FRAME_CYC; c++) begin
                checkOutput($sformatf("vec%0d_c%0d_tx", i, c), bus.tx, expBit(vecs[i], c / N));
                if (c == FRAME_CYC - 1) checkOutput($sformatf("vec%0d_last_busy", i), bus.busy, 1);
                @(negedge CLK);
            end
            checkOutput($sformatf("vec%0d_end_busy", i), bus.busy, 0);
            checkOutput($sformatf("vec%0d_end_tx", i), bus.tx, 1);
        end
        checkOutput("vec_queue_empty", expQ.size(), 0);

        $display("[TB] back-to-back frames");
        f0 = framesSeen;
        s0 = startCycles.size();
        applyStimulus(8'h01, 1);
        applyStimulus(8'h02, 1);
        applyStimulus(8'h03, 1);
        bus.out_wr = 1'b0;
        waitIdle(5 * FRAME_CYC, peak);
        checkOutput("b2b_frames", framesSeen - f0, 3);
        checkOutput("b2b_peak_count", peak, 2);
        checkOutput("b2b_starts", startCycles.size() - s0, 3);
        if (startCycles.size() >= s0 + 3) begin
            checkOutput("b2b_gap1", startCycles[s0+1] - startCycles[s0], FRAME_CYC);
            checkOutput("b2b_gap2", startCycles[s0+2] - startCycles[s0+1], FRAME_CYC);
        end

        $display("[TB] overflow");
        f0 = framesSeen;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h10 + 8'(i), i < 9);
            if (i == 8) begin
                checkOutput("ovf_full", bus.full, 1);
                checkOutput("ovf_count8", bus.fifo_count, DEPTH);
                checkOutput("ovf_not_yet", bus.overflow, 0);
            end
        end
        bus.out_wr = 1'b0;
        checkOutput("ovf_set", bus.overflow, 1);
        checkOutput("ovf_count_held", bus.fifo_count, DEPTH);
        waitIdle(12 * FRAME_CYC, peak);
        checkOutput("ovf_frames", framesSeen - f0, 9);
        checkOutput("ovf_sticky", bus.overflow, 1);
        checkOutput("ovf_queue_empty", expQ.size(), 0);

        $display("[TB] reset mid-START");
        applyStimulus(8'h5A, 1);
        bus.out_wr = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("mrst_in_start", bus.tx, 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("mrst_tx", bus.tx, 1);
        checkOutput("mrst_busy", bus.busy, 0);
        checkOutput("mrst_count", bus.fifo_count, 0);
        checkOutput("mrst_overflow", bus.overflow, 0);
        expQ.delete();
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("mrst_after_tx", bus.tx, 1);
        checkOutput("mrst_after_busy", bus.busy, 0);

        $display("[TB] push on pop while full");
        f0 = framesSeen;
        for (int i = 0; i < 9; i++) applyStimulus(8'h30 + 8'(i), 1);
        bus.out_wr = 1'b0;
        checkOutput("pop_full_before", bus.full, 1);
        repeat (FRAME_CYC + 1 - 9) @(negedge CLK);
        checkOutput("pop_stop_tx", bus.tx, 1);
        checkOutput("pop_count_before", bus.fifo_count, DEPTH);
        applyStimulus(8'h3F, 1);
        bus.out_wr = 1'b0;
        checkOutput("pop_count_after", bus.fifo_count, DEPTH);
        checkOutput("pop_overflow", bus.overflow, 0);
        checkOutput("pop_next_start", bus.tx, 0);
        waitIdle(12 * FRAME_CYC, peak);
        checkOutput("pop_frames", framesSeen - f0, 10);
        checkOutput("pop_queue_empty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
